// File: rtl/alu_pipe.sv
// alu_pipe: integer ALU feeding a STAGES-deep pipeline whose output stage holds until consumed.
// Optional synchronous flush port is built only when ALU_PIPE_FLUSH_EN is defined.

package core_config_pkg;
    parameter int unsigned XLEN       = 32;
    parameter int unsigned REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        c_ADD  = 4'd0,
        c_SUB  = 4'd1,
        c_AND  = 4'd2,
        c_OR   = 4'd3,
        c_XOR  = 4'd4,
        c_SLT  = 4'd5,
        c_SLTU = 4'd6,
        c_SLL  = 4'd7,
        c_SRL  = 4'd8,
        c_SRA  = 4'd9
    } alu_commands_t;
endpackage

module alu_pipe #(
    parameter int unsigned XLEN       = core_config_pkg::XLEN,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [XLEN-1:0]               arg0,
    input  logic [XLEN-1:0]               arg1,
    input  core_config_pkg::alu_commands_t cmd,
    input  logic [REG_ADDR_W-1:0]         i_rd,
    input  logic                          clear,
`ifdef ALU_PIPE_FLUSH_EN
    input  logic                          flush,
`endif
    output logic                          busy,
    output logic                          i_error,
    output logic [XLEN-1:0]               res,
    output logic [REG_ADDR_W-1:0]         o_rd,
    output logic                          valid,
    output logic                          o_error
);

    localparam int unsigned SHW = $clog2(XLEN);
    // Each stage word packs {carry/borrow, destination tag, result}.
    localparam int unsigned DW  = XLEN + REG_ADDR_W + 1;

    logic                          w_supported;
    logic [XLEN-1:0]               w_result;
    logic                          w_carry;
    logic [XLEN:0]                 w_sum;
    logic [XLEN:0]                 w_diff;
    logic [SHW-1:0]                w_shamt;
    logic                          w_stall;
    logic                          w_accept;
    logic [DW-1:0]                 w_stage_in;
    logic [STAGES-1:0]             w_vld_next;
    logic [STAGES-1:0][DW-1:0]     w_data_next;

    logic [STAGES-1:0]             r_vld;
    logic [STAGES-1:0][DW-1:0]     r_data;
    logic                          r_ierr;

    assign w_sum   = {1'b0, arg0} + {1'b0, arg1};
    assign w_diff  = {1'b0, arg0} - {1'b0, arg1};
    assign w_shamt = arg1[SHW-1:0];

    always_comb begin
        w_supported = 1'b1;
        w_result    = '0;
        w_carry     = 1'b0;
        case (cmd)
            core_config_pkg::c_ADD: begin
                w_result = w_sum[XLEN-1:0];
                w_carry  = w_sum[XLEN];
            end
            core_config_pkg::c_SUB: begin
                w_result = w_diff[XLEN-1:0];
                w_carry  = w_diff[XLEN];
            end
            core_config_pkg::c_AND:  w_result = arg0 & arg1;
            core_config_pkg::c_OR:   w_result = arg0 | arg1;
            core_config_pkg::c_XOR:  w_result = arg0 ^ arg1;
            core_config_pkg::c_SLT:  w_result = {{(XLEN-1){1'b0}}, $signed(arg0) < $signed(arg1)};
            core_config_pkg::c_SLTU: w_result = {{(XLEN-1){1'b0}}, arg0 < arg1};
            core_config_pkg::c_SLL:  w_result = arg0 << w_shamt;
            core_config_pkg::c_SRL:  w_result = arg0 >> w_shamt;
            core_config_pkg::c_SRA:  w_result = $signed(arg0) >>> w_shamt;
            default:                 w_supported = 1'b0;
        endcase
    end

    // An unconsumed result freezes the whole pipe, including bubbles ahead of it.
    assign w_stall    = r_vld[STAGES-1] & ~clear;
    assign w_accept   = i_valid & ~w_stall & w_supported;
    assign w_stage_in = {w_carry, i_rd, w_result};

    if (STAGES == 1) begin : g_single
        assign w_vld_next  = w_accept;
        assign w_data_next = w_stage_in;
    end else begin : g_multi
        assign w_vld_next  = {r_vld[STAGES-2:0], w_accept};
        assign w_data_next = {r_data[STAGES-2:0], w_stage_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_data <= '0;
            r_ierr <= 1'b0;
        end else begin
`ifdef ALU_PIPE_FLUSH_EN
            if (flush) begin
                r_vld  <= '0;
                r_ierr <= 1'b0;
            end else begin
`endif
                r_ierr <= i_valid & ~w_stall & ~w_supported;
                if (!w_stall) begin
                    r_vld  <= w_vld_next;
                    r_data <= w_data_next;
                end
`ifdef ALU_PIPE_FLUSH_EN
            end
`endif
        end
    end

    assign busy                  = w_stall;
    assign i_error               = r_ierr;
    assign valid                 = r_vld[STAGES-1];
    assign {o_error, o_rd, res}  = r_data[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (STAGES=2): issue side pushes expectations, monitor pops on retire.
module tb_alu_pipe;
    import core_config_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned EW = W + RW + 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          i_valid = 1'b0;
    logic          clear   = 1'b0;
    logic [W-1:0]  arg0    = '0;
    logic [W-1:0]  arg1    = '0;
    logic [3:0]    cmd_raw = 4'd0;
    logic [RW-1:0] i_rd    = '0;
`ifdef ALU_PIPE_FLUSH_EN
    logic          flush   = 1'b0;
`endif
    logic          busy;
    logic          i_error;
    logic          valid;
    logic          o_error;
    logic [W-1:0]  res;
    logic [RW-1:0] o_rd;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] sb[$];

    always #5 clk = ~clk;

    alu_pipe #(
        .XLEN      (W),
        .STAGES    (2),
        .REG_ADDR_W(RW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .arg0   (arg0),
        .arg1   (arg1),
        .cmd    (alu_commands_t'(cmd_raw)),
        .i_rd   (i_rd),
        .clear  (clear),
`ifdef ALU_PIPE_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .i_error(i_error),
        .res    (res),
        .o_rd   (o_rd),
        .valid  (valid),
        .o_error(o_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds the op on the inputs until busy drops, then lets it be sampled on the next edge.
    task automatic issue(input alu_commands_t c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rd, input logic [W-1:0] r, input logic e);
        int n = 0;
        i_valid = 1'b1;
        cmd_raw = c;
        arg0    = a;
        arg1    = b;
        i_rd    = rd;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_accepted", busy, 0);
        sb.push_back({e, rd, r});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && valid && clear) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    chk("retire", {o_error, o_rd, res}, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_i_error", i_error, 0);
        chk("rst_res", res, 0);
        chk("rst_o_rd", o_rd, 0);
        chk("rst_valid", valid, 0);
        chk("rst_o_error", o_error, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear = 1'b1;

        // ADD overflow with latency check: valid only after the second edge
        issue(c_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("latency_stage1", valid, 0);
        @(negedge clk);
        chk("latency_stage2", valid, 1);
        @(posedge clk);
        #1;

        // Back-to-back mix of operations, clear held high
        issue(c_SUB,  32'd5,         32'd7,         5'd1, 32'hFFFF_FFFE, 1'b1);
        issue(c_SUB,  32'd7,         32'd5,         5'd2, 32'h0000_0002, 1'b0);
        issue(c_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4, 32'h00F0_00F0, 1'b0);
        issue(c_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 32'hFFF0_FFF0, 1'b0);
        issue(c_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 32'hFF00_FF00, 1'b0);
        issue(c_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd7, 32'h0000_0001, 1'b0);
        issue(c_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 32'h0000_0000, 1'b0);
        issue(c_SLL,  32'h0000_0001, 32'h0000_001F, 5'd9, 32'h8000_0000, 1'b0);
        issue(c_SRA,  32'h8000_0000, 32'h0000_0024, 5'd10, 32'hF800_0000, 1'b0);
        issue(c_SRL,  32'h8000_0000, 32'h0000_0024, 5'd11, 32'h0800_0000, 1'b0);
        drain();

        // Stall: four ADDs with clear low, then release
        clear = 1'b0;
        fork
            begin
                issue(c_ADD, 32'h10, 32'h1, 5'd1, 32'h11, 1'b0);
                issue(c_ADD, 32'h20, 32'h2, 5'd2, 32'h22, 1'b0);
                issue(c_ADD, 32'h30, 32'h3, 5'd3, 32'h33, 1'b0);
                issue(c_ADD, 32'h40, 32'h4, 5'd4, 32'h44, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_busy", busy, 1);
                chk("stall_valid", valid, 1);
                chk("stall_res_hold", res, 32'h11);
                chk("stall_rd_hold", o_rd, 1);
                clear = 1'b1;
            end
        join
        drain();

        // Unsupported command: one-cycle i_error, no result
        i_valid = 1'b1;
        cmd_raw = 4'd12;
        i_rd    = 5'd15;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("illegal_i_error", i_error, 1);
        @(posedge clk);
        #1;
        chk("illegal_i_error_pulse", i_error, 0);
        repeat (3) begin
            @(negedge clk);
            chk("illegal_no_valid", valid, 0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset with two ops in flight
        clear = 1'b0;
        issue(c_ADD, 32'h100, 32'h1, 5'd5, 32'h101, 1'b0);
        issue(c_ADD, 32'h200, 32'h2, 5'd6, 32'h202, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_res", res, 0);
        chk("async_rst_o_rd", o_rd, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_o_error", o_error, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_stale", valid, 0);
        end
        @(posedge clk);
        #1;
        issue(c_XOR, 32'h0000_FFFF, 32'h0000_00FF, 5'd12, 32'h0000_FF00, 1'b0);
        drain();

`ifdef ALU_PIPE_FLUSH_EN
        // Flush with a same-cycle issue: both in-flight and new op discarded
        i_valid = 1'b1;
        cmd_raw = c_ADD;
        arg0    = 32'd1;
        arg1    = 32'd1;
        i_rd    = 5'd7;
        @(posedge clk);
        #1;
        flush = 1'b1;
        arg0  = 32'd2;
        i_rd  = 5'd8;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        i_valid = 1'b0;
        chk("flush_valid", valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_result", valid, 0);
        end
        @(posedge clk);
        #1;
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
